uart_tx: RTL
============

# uart_tx

Byte-serial UART transmitter with a small transmit FIFO. It is the send side of the host serial link that feeds `bali`'s `rx` input, and it drives the host-bound `tx` line. Upstream logic pushes bytes over a valid/ready handshake, and the block serialises them as 8N1 frames at a fixed baud. The same block also serves as the bench-side driver for host-to-core traffic, replacing hand-timed bit loops.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: clock cycles per serial bit (100 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte to transmit.
- `valid`  in  1  `data_in` is presented for transmission.
- `ready`  out  1  FIFO can accept a byte; transfer occurs on a rising edge with `valid && ready`.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `count`=0. The FSM is in IDLE and the FIFO pointers are zero.
- Frame format:
  - start bit (0);
  - `data_in[0]` through `data_in[7]`, LSB first;
  - one stop bit (1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, set `tx`=0, clear the baud counter, and go to START.
  - START: hold `tx`=0 for `CLKS_PER_BIT` cycles. Then set `tx`=shift[0], clear the bit index, and go to DATA.
  - DATA: each bit is held `CLKS_PER_BIT` cycles, then the register shifts right and the index increments. After bit 7 completes, set `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and enter START directly with no idle gap; otherwise go to IDLE.
- Baud counter: 0 … `CLKS_PER_BIT`-1, wrapping at each bit boundary. Bit index is 3 bits.
- FIFO:
  - `ready` = (`count` != `FIFO_DEPTH`).
  - Simultaneous push and pop leaves `count` unchanged.
  - Push while full is impossible, because `ready` is low.
  - There is no bypass: a byte always passes through the FIFO.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `busy` = (state != IDLE) || (`count` != 0).
- `data_in` is ignored when `valid` is low or `ready` is low.

## Timing
- Accept at edge k with the FSM in IDLE and the FIFO empty: pop at edge k+1, and `tx` falls after edge k+1.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- `ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the next pop.
- `busy` falls the cycle after the STOP bit ends, provided the FIFO is empty.
- Reset asserted mid-frame:
  - `tx` goes high immediately (asynchronous);
  - the frame is aborted and the FIFO is emptied;
  - no partial byte is resumed after release.
- First transfer after reset release may occur on the first rising edge with `rst` high.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_state_t` enum (IDLE/START/DATA/STOP);
  - constants `UART_START_BIT`=1'b0, `UART_STOP_BIT`=1'b1, `UART_DATA_BITS`=8.
- One sub-module, `sync_fifo`: parameterised width and depth, push/pop/full/empty/count, asynchronous active-low `rst`. `uart_tx` instantiates it with width 8. The serialiser FSM lives in `uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- **Single byte.** Push 0xA5 while idle.
  - `tx` low 1 cycle after accept, held 16 cycles.
  - Data bits 1,0,1,0,0,1,0,1, 16 cycles each; stop high for 16.
  - `busy` high for 161 cycles total.
- **Burst.** Push 0x00, 0x01, 0x02 on consecutive cycles.
  - Three contiguous frames totalling 480 cycles, with no idle high between stop and start.
  - A mid-bit-sampling rx model recovers 0x00, 0x01, 0x02.
- **Backpressure.** Push bytes 0x10 through 0x15 with `valid` held high every cycle.
  - Five bytes are accepted in the first 5 cycles, one popped immediately plus 4 queued.
  - `ready` is low from cycle 5 until 0x10's stop bit ends.
  - 0x15 is accepted the cycle after that pop; all six bytes are transmitted in order.
- **Reset mid-frame.**
  - Push 0x3C and 0x7E; assert `rst` during bit 3 of 0x3C.
  - Immediately: `tx`=1, `count`=0, `ready`=1, `busy`=0.
  - After release, push 0x81: exactly one clean 0x81 frame; nothing of 0x7E is sent.
- **Exhaustive loopback.** Push 0x00 through 0xFF.
  - The rx model recovers all 256 bytes in order.
  - No framing error: stop bit is high on every frame.
  - Total 2560·16 cycles from first start bit to last stop end.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and framing constants.
// Used by the transmitter FSM, its interface and the bench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte push handshake (valid/ready) plus serial line and status of uart_tx.
// The producer uses master; the transmitter uses slave.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [UART_DATA_BITS-1:0] data_in;
  logic                      valid;
  logic                      ready;
  logic                      tx;
  logic                      busy;
  logic [CW-1:0]             count;

  modport master (
    output data_in, valid,
    input  ready, tx, busy, count
  );

  modport slave (
    input  data_in, valid,
    output ready, tx, busy, count
  );

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO, head visible combinationally; one cycle from push to non-empty.
// Pushes while full and pops while empty are dropped internally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed through a small FIFO; tx falls one cycle after an idle accept.
// ready drops only while the FIFO is full; back-to-back frames leave no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

  tx_state_t                 r_state;
  tx_state_t                 w_state_nxt;
  logic [CNT_W-1:0]          r_baud;
  logic [CNT_W-1:0]          w_baud_nxt;
  logic [2:0]                r_idx;
  logic [2:0]                w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_bit_end;
  logic [UART_DATA_BITS-1:0] w_head;
  logic [CW-1:0]             w_count;

  assign w_push    = bus.valid && !w_full;
  assign w_bit_end = (r_baud == LAST_CNT);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (bus.data_in),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= UART_STOP_BIT;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = UART_STOP_BIT;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = UART_START_BIT;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_tx_nxt    = UART_STOP_BIT;
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // A queued byte starts its frame straight out of the stop bit.
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = UART_START_BIT;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = UART_STOP_BIT;
      end
    endcase
  end

  assign bus.tx    = r_tx;
  assign bus.ready = !w_full;
  assign bus.busy  = (r_state != IDLE) || (w_count != '0);
  assign bus.count = w_count;

endmodule
